// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller.
package mc_pkg;

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StIExec    = 4'd9,
    StIWb      = 4'd10,
    StBranch   = 4'd11,
    StJump     = 4'd12,
    StHalt     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_mem_state(state_t s);
    return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
  endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational map from controller state (plus mem_ready in FETCH) to datapath strobes.
module multicycle_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR and PC load only once the fetch data is actually there.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StRExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      StRWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StIExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      StIWb: begin
        ctrl.reg_write = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: state register, next-state logic and memory wait timeout.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       mem_error,
  output logic [3:0] state
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             is_store_q, is_store_d;
  logic             mem_error_q, mem_error_d;
  logic             wait_hit, timeout, illegal_c;
  ctrl_t            ctrl;

  assign wait_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                    (wait_q == WaitW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    timeout    = 1'b0;
    illegal_c  = 1'b0;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        if (mem_ready)     state_d = StDecode;
        else if (wait_hit) timeout = 1'b1;
      end
      StDecode: begin
        // lw/sw choice is captured here so later opcode changes cannot redirect MEM_ADDR.
        is_store_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_d = StRExec;
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_ADDI:      state_d = StIExec;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_c = 1'b1;
          end
        endcase
      end
      StMemAddr: state_d = is_store_q ? StMemWrite : StMemRead;
      StMemRead: begin
        if (mem_ready)     state_d = StMemWb;
        else if (wait_hit) timeout = 1'b1;
      end
      StMemWrite: begin
        if (mem_ready)     state_d = StFetch;
        else if (wait_hit) timeout = 1'b1;
      end
      StRExec:  state_d = StRWb;
      StIExec:  state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StReset;
    endcase
    if (timeout) state_d = StHalt;
  end

  always_comb begin
    mem_error_d = mem_error_q | timeout;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (is_mem_state(state_q) && !mem_ready && (wait_q != '1)) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReset;
      wait_q      <= '0;
      is_store_q  <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      is_store_q  <= is_store_d;
      mem_error_q <= mem_error_d;
    end
  end

  multicycle_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal       = illegal_c;
  assign mem_error     = mem_error_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level reference model.
module tb_multicycle_control;
  import mc_pkg::*;

  localparam int unsigned TO = 4;

  logic       clk, rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_dst, reg_write, mem_to_reg, alu_src_a, illegal, mem_error;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  bit halted   = 0;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal),
    .mem_error     (mem_error),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic known_op(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_ADDI ||
           op == OP_BEQ || op == OP_J;
  endfunction

  // Expected strobes for one cycle, straight from the per-state output table.
  function automatic logic [31:0] exp_ctl(state_t st, logic rdy, logic [5:0] op);
    logic pcw, pcwc, irw, iord, mr, mw, rd, rw, m2r, asa, ill, merr;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, irw, iord, mr, mw, rd, rw, m2r, asa, ill, merr} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      StFetch:    begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      StDecode:   begin asb = 2'b11; ill = !known_op(op); end
      StMemAddr:  begin asa = 1; asb = 2'b10; end
      StMemRead:  begin mr = 1; iord = 1; end
      StMemWb:    begin rw = 1; m2r = 1; end
      StMemWrite: begin mw = 1; iord = 1; end
      StRExec:    begin asa = 1; aop = 2'b10; end
      StRWb:      begin rw = 1; rd = 1; end
      StIExec:    begin asa = 1; asb = 2'b10; end
      StIWb:      begin rw = 1; end
      StBranch:   begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      StJump:     begin pcw = 1; psrc = 2'b10; end
      StHalt:     begin merr = 1; end
      default: ;
    endcase
    return {14'b0, pcw, pcwc, irw, iord, mr, mw, rd, rw, m2r, asa, asb, aop, psrc, ill, merr};
  endfunction

  function automatic logic [31:0] obs_ctl();
    return {14'b0, pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_dst,
            reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal, mem_error};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic cyc(state_t st, logic rdy, logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    #1;
    check($sformatf("state %s", st.name()), {28'b0, state}, {28'b0, st});
    check($sformatf("ctl %s", st.name()), obs_ctl(), exp_ctl(st, rdy, op));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("reset state", {28'b0, state}, 32'd0);
    check("reset ctl", obs_ctl(), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    check("post-reset state", {28'b0, state}, 32'd0);
    check("post-reset ctl", obs_ctl(), 32'd0);
    halted = 0;
  endtask

  // w not-ready cycles, then one ready cycle, unless the timeout is reached first.
  task automatic mem_phase(state_t st, int w);
    for (int i = 0; i < w; i++) begin
      cyc(st, 1'b0, rnd_op());
      if (i + 1 == int'(TO)) begin
        halted = 1;
        return;
      end
    end
    cyc(st, 1'b1, rnd_op());
  endtask

  task automatic halt_tail();
    for (int i = 0; i < 3; i++) cyc(StHalt, 1'($urandom), rnd_op());
    apply_reset();
  endtask

  task automatic run_instr(logic [5:0] op, int wf, int wm);
    mem_phase(StFetch, wf);
    if (!halted) begin
      cyc(StDecode, 1'($urandom), op);
      case (op)
        OP_RTYPE: begin cyc(StRExec, 1'($urandom), rnd_op()); cyc(StRWb, 1'($urandom), rnd_op()); end
        OP_LW: begin
          cyc(StMemAddr, 1'($urandom), rnd_op());
          mem_phase(StMemRead, wm);
          if (!halted) cyc(StMemWb, 1'($urandom), rnd_op());
        end
        OP_SW: begin
          cyc(StMemAddr, 1'($urandom), rnd_op());
          mem_phase(StMemWrite, wm);
        end
        OP_ADDI: begin cyc(StIExec, 1'($urandom), rnd_op()); cyc(StIWb, 1'($urandom), rnd_op()); end
        OP_BEQ:  cyc(StBranch, 1'($urandom), rnd_op());
        OP_J:    cyc(StJump, 1'($urandom), rnd_op());
        default: ;
      endcase
    end
    if (halted) halt_tail();
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [5:0] ops [6];
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = '0;
    apply_reset();

    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_LW, 0, 2);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(OP_RTYPE, 4, 0);
    run_instr(OP_RTYPE, 3, 0);
    run_instr(OP_SW, 3, 3);
    run_instr(OP_LW, 1, 4);

    // Reset while a store is waiting on memory: strobes must drop without a clock edge.
    cyc(StFetch, 1'b1, rnd_op());
    cyc(StDecode, 1'b0, OP_SW);
    cyc(StMemAddr, 1'b0, OP_LW);
    cyc(StMemWrite, 1'b0, rnd_op());
    #2;
    rst_n = 1'b0;
    #1;
    check("async mem_write drop", {31'b0, mem_write}, 32'd0);
    apply_reset();
    run_instr(OP_RTYPE, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 6) == 0) ? rnd_op() : ops[$urandom_range(0, 5)];
      run_instr(op, rnd_wait(), rnd_wait());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
